// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller and the ID/EXE
//   pipeline register. The ID/EXE register uses the same write-enable
//   constants, so both sides share one definition of "load" and "bubble".
//
//   Contents:
//     haz_state_t    - debug FSM encoding (RUN / DATA_STALL / HILO_WAIT)
//     ID_EXE_LOAD    - ID/EXE write bus value that loads the register
//     ID_EXE_BUBBLE  - ID/EXE write bus value that inserts a bubble
//     haz_next_state - cause-to-state mapping; HI/LO wait has precedence
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DATA_STALL = 2'd1,
        HILO_WAIT  = 2'd2
    } haz_state_t;

    localparam logic [2:0] ID_EXE_LOAD   = 3'b111;
    localparam logic [2:0] ID_EXE_BUBBLE = 3'b000;

    // The next state depends only on this cycle's causes, never on the
    // current state, so the unused encoding 3 falls back to RUN on its own.
    function automatic haz_state_t haz_next_state(input logic hilo_cause,
                                                  input logic data_cause);
        if (hilo_cause) begin
            return HILO_WAIT;
        end else if (data_cause) begin
            return DATA_STALL;
        end
        return RUN;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hilo_busy_counter.sv
// ---------------------------------------------------------------------------
// hilo_busy_counter
//   Tracks how long the multiply/divide unit keeps HI/LO busy after a
//   mult/div issues to EXE. A start reloads the counter with MD_LAT (also
//   while it is still counting); otherwise it decrements and saturates at 0.
//
//   Parameters:
//     MD_LAT   - mult/div latency in cycles after issue to EXE
//   Ports:
//     clock    in   pipeline clock, posedge
//     reset_n  in   asynchronous active-low reset; clears the count
//     md_start in   EXE holds a mult/div this cycle
//     busy     out  counter is nonzero (HI/LO result still pending)
// ---------------------------------------------------------------------------
module hilo_busy_counter #(
    parameter int MD_LAT = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic md_start,
    output logic busy
);

    // Wide enough to hold MD_LAT itself; never narrower than one bit.
    localparam int MD_CNT_W = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT);

    logic [MD_CNT_W-1:0] md_cnt_reg;
    logic [MD_CNT_W-1:0] md_cnt_next;

    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (md_start) begin
            md_cnt_next = MD_LOAD;
        end else if (md_cnt_reg != '0) begin
            md_cnt_next = md_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_reg <= '0;
        end else begin
            md_cnt_reg <= md_cnt_next;
        end
    end

    assign busy = (md_cnt_reg != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard detection beside the ID stage. Drives the PC / IF-ID enables, the
//   IF/ID flush and the 3-bit ID/EXE write bus. Any hazard (load-use,
//   branch-operand, HI/LO busy) freezes PC and IF/ID and bubbles ID/EXE.
//   Outputs are combinational; pipeline registers sample on negedge.
//
//   Optional build macro: HAZ_PERF_CNT_EN
//     defined   - saturating stall_cycles / flush_count counters
//     undefined - both ports tied to 0, no counter flops
//
//   Parameters: REG_W (register index width), MD_LAT (mult/div latency),
//               CNT_W (perf counter width)
//   Ports:
//     clock, reset_n            clock (posedge) / async active-low reset
//     id_rs, id_rt              ID source register indices
//     id_use_rs, id_use_rt      ID instruction reads rs / rt
//     id_is_branch              ID compares operands in ID (beq/jr)
//     id_use_hilo               ID instruction is mfhi/mflo
//     id_redirect               ID resolved a taken branch / jump
//     exe_mem_read              EXE instruction is a load
//     exe_reg_write, exe_dst    EXE writes register exe_dst
//     exe_md_start              EXE holds a mult/div this cycle
//     mem_mem_read, mem_dst     MEM load targeting mem_dst
//     pc_write, if_id_write     update enables
//     if_id_flush               zero IF/ID on next update
//     id_exe_write              111 = load, 000 = bubble
//     haz_state                 previous cycle's stall cause (debug only)
//     stall_cycles, flush_count optional perf counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_use_hilo,
    input  logic             id_redirect,
    input  logic             exe_mem_read,
    input  logic             exe_reg_write,
    input  logic [REG_W-1:0] exe_dst,
    input  logic             exe_md_start,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_dst,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic [2:0]       id_exe_write,
    output logic [1:0]       haz_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // -----------------------------------------------------------------------
    // Operand matching: source 0 = rs, source 1 = rt. $0 never matches.
    // -----------------------------------------------------------------------
    logic [REG_W-1:0] src_idx [2];
    logic [1:0]       src_use;
    logic [1:0]       match_exe;
    logic [1:0]       match_mem;

    assign src_idx[0] = id_rs;
    assign src_idx[1] = id_rt;
    assign src_use    = {id_use_rt, id_use_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
            assign match_exe[gi] = src_use[gi] && (exe_dst != '0) &&
                                   (src_idx[gi] == exe_dst);
            assign match_mem[gi] = src_use[gi] && (mem_dst != '0) &&
                                   (src_idx[gi] == mem_dst);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Hazard causes
    // -----------------------------------------------------------------------
    logic md_busy;
    logic load_use;
    logic br_hazard;
    logic hilo_hazard;
    logic stall;
    logic flush_req;

    hilo_busy_counter #(
        .MD_LAT (MD_LAT)
    ) u_hilo_busy (
        .clock    (clock),
        .reset_n  (reset_n),
        .md_start (exe_md_start),
        .busy     (md_busy)
    );

    assign load_use = exe_mem_read && (|match_exe);

    // A branch needs its operands in ID: any EXE writer is too late, and a
    // MEM load is still too late, so a branch behind a load waits twice.
    assign br_hazard = id_is_branch &&
                       ((exe_reg_write && (|match_exe)) ||
                        (mem_mem_read  && (|match_mem)));

    // exe_md_start covers the issue cycle, before the counter has loaded.
    assign hilo_hazard = id_use_hilo && (md_busy || exe_md_start);

    assign stall = load_use || br_hazard || hilo_hazard;

    // Redirect resolved from stale operands is meaningless during a stall.
    assign flush_req = !stall && id_redirect;

    // -----------------------------------------------------------------------
    // Debug FSM: state register / next-state / outputs
    // -----------------------------------------------------------------------
    haz_state_t state_reg;
    haz_state_t state_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = haz_next_state(hilo_hazard, load_use || br_hazard);
    end

    // Outputs depend on the causes, not on the state; reset forces a safe
    // frozen pipeline with IF/ID held flushed.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = flush_req;
        id_exe_write = ID_EXE_LOAD;
        if (!reset_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_write = ID_EXE_BUBBLE;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_exe_write = ID_EXE_BUBBLE;
        end
    end

    assign haz_state = state_reg;

    // -----------------------------------------------------------------------
    // Optional performance counters (saturating)
    // -----------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] flush_count_reg;

    // flush_req equals if_id_flush whenever reset_n is high, which is the
    // only time these counters advance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (flush_req && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Inputs change on negedge, outputs
//   are sampled 1 time unit later; haz_state at that point reflects the
//   cause present in the previous cycle. Control outputs are compared as a
//   packed vector {pc_write, if_id_write, if_id_flush, id_exe_write}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    localparam logic [5:0] C_RUN   = 6'b110111;
    localparam logic [5:0] C_FLUSH = 6'b111111;
    localparam logic [5:0] C_STALL = 6'b000000;
    localparam logic [5:0] C_RESET = 6'b001000;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [REG_W-1:0] id_rs, id_rt, exe_dst, mem_dst;
    logic             id_use_rs, id_use_rt, id_is_branch, id_use_hilo;
    logic             id_redirect, exe_mem_read, exe_reg_write;
    logic             exe_md_start, mem_mem_read;
    logic             pc_write, if_id_write, if_id_flush;
    logic [2:0]       id_exe_write;
    logic [1:0]       haz_state;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [5:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    assign ctrl = {pc_write, if_id_write, if_id_flush, id_exe_write};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.REG_W(REG_W), .MD_LAT(4), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_is_branch  (id_is_branch),
        .id_use_hilo   (id_use_hilo),
        .id_redirect   (id_redirect),
        .exe_mem_read  (exe_mem_read),
        .exe_reg_write (exe_reg_write),
        .exe_dst       (exe_dst),
        .exe_md_start  (exe_md_start),
        .mem_mem_read  (mem_mem_read),
        .mem_dst       (mem_dst),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_exe_write  (id_exe_write),
        .haz_state     (haz_state),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic set_idle();
        id_rs = '0; id_rt = '0; exe_dst = '0; mem_dst = '0;
        id_use_rs = 0; id_use_rt = 0; id_is_branch = 0; id_use_hilo = 0;
        id_redirect = 0; exe_mem_read = 0; exe_reg_write = 0;
        exe_md_start = 0; mem_mem_read = 0;
    endtask

    task automatic test_reset();
        set_idle();
        id_redirect = 1;
        exe_md_start = 1;
        #2;
        n_checks++;
        if (ctrl !== C_RESET) begin
            $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RESET); n_fail++;
        end
        n_checks++;
        if (haz_state !== 2'd0 || stall_cycles !== '0 || flush_count !== '0) begin
            $display("FAIL reset_state: state %0d stalls %0d flushes %0d want 0 0 0",
                     haz_state, stall_cycles, flush_count); n_fail++;
        end
        // md start during reset must not load the counter
        @(negedge clock);
        set_idle();
        reset_n = 1;
        id_use_hilo = 1;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin
            $display("FAIL reset_release: got %b want %b", ctrl, C_RUN); n_fail++;
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        @(negedge clock);
        set_idle();
        exe_mem_read = 1; exe_reg_write = 1; exe_dst = 5'd8;
        id_rs = 5'd8; id_use_rs = 1;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin
            $display("FAIL load_use_stall: got %b want %b", ctrl, C_STALL); n_fail++;
        end
        @(negedge clock);
        set_idle();
        mem_mem_read = 1; mem_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
        #1;
        n_checks++;
        if (ctrl !== C_RUN || haz_state !== 2'd1) begin
            $display("FAIL load_use_after: ctrl %b state %0d want %b 1",
                     ctrl, haz_state, C_RUN); n_fail++;
        end
        // rt path of the matcher
        @(negedge clock);
        set_idle();
        exe_mem_read = 1; exe_dst = 5'd17; id_rt = 5'd17; id_use_rt = 1;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin
            $display("FAIL load_use_rt: got %b want %b", ctrl, C_STALL); n_fail++;
        end
        @(negedge clock);
        set_idle();
        #1;
        n_checks++;
        if (ctrl !== C_RUN || haz_state !== 2'd1) begin
            $display("FAIL load_use_rt_after: ctrl %b state %0d want %b 1",
                     ctrl, haz_state, C_RUN); n_fail++;
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (haz_state !== 2'd0) begin
            $display("FAIL load_use_back_to_run: state %0d want 0", haz_state); n_fail++;
        end
        $display("test_load_use done");
    endtask

    task automatic test_zero_and_qualify();
        @(negedge clock);
        set_idle();
        exe_mem_read = 1; exe_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin
            $display("FAIL zero_reg: got %b want %b", ctrl, C_RUN); n_fail++;
        end
        @(negedge clock);
        set_idle();
        exe_mem_read = 1; exe_dst = 5'd8; id_rs = 5'd8; id_use_rs = 0;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin
            $display("FAIL unused_rs: got %b want %b", ctrl, C_RUN); n_fail++;
        end
        // non-branch behind a MEM load is forwarded, no stall
        @(negedge clock);
        set_idle();
        mem_mem_read = 1; mem_dst = 5'd3; id_rs = 5'd3; id_use_rs = 1;
        #1;
        n_checks++;
        if (ctrl !== C_RUN || haz_state !== 2'd0) begin
            $display("FAIL mem_load_nonbranch: ctrl %b state %0d want %b 0",
                     ctrl, haz_state, C_RUN); n_fail++;
        end
        $display("test_zero_and_qualify done");
    endtask

    task automatic test_branch();
        @(negedge clock);
        set_idle();
        id_is_branch = 1; id_rs = 5'd9; id_use_rs = 1; id_redirect = 1;
        exe_mem_read = 1; exe_reg_write = 1; exe_dst = 5'd9;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin
            $display("FAIL branch_exe: got %b want %b", ctrl, C_STALL); n_fail++;
        end
        @(negedge clock);
        exe_mem_read = 0; exe_reg_write = 0; exe_dst = 5'd0;
        mem_mem_read = 1; mem_dst = 5'd9;
        #1;
        n_checks++;
        if (ctrl !== C_STALL || haz_state !== 2'd1) begin
            $display("FAIL branch_mem: ctrl %b state %0d want %b 1",
                     ctrl, haz_state, C_STALL); n_fail++;
        end
        @(negedge clock);
        mem_mem_read = 0; mem_dst = 5'd0;
        #1;
        n_checks++;
        if (ctrl !== C_FLUSH) begin
            $display("FAIL branch_redirect: got %b want %b", ctrl, C_FLUSH); n_fail++;
        end
        // ALU writer in EXE also blocks a branch
        @(negedge clock);
        set_idle();
        id_is_branch = 1; id_rt = 5'd12; id_use_rt = 1;
        exe_reg_write = 1; exe_dst = 5'd12;
        #1;
        n_checks++;
        if (ctrl !== C_STALL || haz_state !== 2'd0) begin
            $display("FAIL branch_alu: ctrl %b state %0d want %b 0",
                     ctrl, haz_state, C_STALL); n_fail++;
        end
        $display("test_branch done");
    endtask

    task automatic test_hilo();
        logic exp_stall;
        logic [1:0] exp_state;
        @(negedge clock);
        set_idle();
        #1;
        // single start: stall for start cycle + 4
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            set_idle();
            id_use_hilo = 1;
            exe_md_start = (i == 0);
            exp_stall = (i <= 4);
            exp_state = (i >= 1 && i <= 5) ? 2'd2 : 2'd0;
            #1;
            n_checks++;
            if (ctrl !== (exp_stall ? C_STALL : C_RUN) || haz_state !== exp_state) begin
                $display("FAIL hilo_single[%0d]: ctrl %b state %0d want %b %0d",
                         i, ctrl, haz_state, exp_stall ? C_STALL : C_RUN, exp_state);
                n_fail++;
            end
        end
        // restart at cycle 2 extends the wait to cycle 6
        for (int i = 0; i <= 8; i++) begin
            @(negedge clock);
            set_idle();
            id_use_hilo = 1;
            exe_md_start = (i == 0 || i == 2);
            exp_stall = (i <= 6);
            exp_state = (i >= 1 && i <= 7) ? 2'd2 : 2'd0;
            #1;
            n_checks++;
            if (ctrl !== (exp_stall ? C_STALL : C_RUN) || haz_state !== exp_state) begin
                $display("FAIL hilo_restart[%0d]: ctrl %b state %0d want %b %0d",
                         i, ctrl, haz_state, exp_stall ? C_STALL : C_RUN, exp_state);
                n_fail++;
            end
        end
        // simultaneous load-use and hilo: state shows HILO_WAIT
        @(negedge clock);
        set_idle();
        id_use_hilo = 1; exe_md_start = 1;
        exe_mem_read = 1; exe_dst = 5'd4; id_rs = 5'd4; id_use_rs = 1;
        #1;
        n_checks++;
        if (ctrl !== C_STALL) begin
            $display("FAIL both_causes: got %b want %b", ctrl, C_STALL); n_fail++;
        end
        @(negedge clock);
        set_idle();
        #1;
        n_checks++;
        if (ctrl !== C_RUN || haz_state !== 2'd2) begin
            $display("FAIL hilo_precedence: ctrl %b state %0d want %b 2",
                     ctrl, haz_state, C_RUN); n_fail++;
        end
        $display("test_hilo done");
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clock);
        set_idle();
        id_use_hilo = 1; exe_md_start = 1;
        @(negedge clock);
        exe_md_start = 0;
        #2;
        reset_n = 0;
        #1;
        n_checks++;
        if (ctrl !== C_RESET || haz_state !== 2'd0) begin
            $display("FAIL reset_mid_stall: ctrl %b state %0d want %b 0",
                     ctrl, haz_state, C_RESET); n_fail++;
        end
        @(negedge clock);
        reset_n = 1;
        #1;
        n_checks++;
        if (ctrl !== C_RUN) begin
            $display("FAIL md_cnt_cleared: got %b want %b", ctrl, C_RUN); n_fail++;
        end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] exp_stalls;
        logic [CNT_W-1:0] exp_flushes;
`ifdef HAZ_PERF_CNT_EN
        exp_stalls = 16'd3; exp_flushes = 16'd2;
`else
        exp_stalls = 16'd0; exp_flushes = 16'd0;
`endif
        @(negedge clock);
        set_idle();
        reset_n = 0;
        #1;
        n_checks++;
        if (stall_cycles !== '0 || flush_count !== '0) begin
            $display("FAIL perf_cleared: stalls %0d flushes %0d want 0 0",
                     stall_cycles, flush_count); n_fail++;
        end
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        exe_mem_read = 1; exe_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
        @(negedge clock);
        set_idle();
        id_is_branch = 1; id_rs = 5'd9; id_use_rs = 1;
        exe_mem_read = 1; exe_reg_write = 1; exe_dst = 5'd9;
        @(negedge clock);
        exe_mem_read = 0; exe_reg_write = 0; exe_dst = 5'd0;
        mem_mem_read = 1; mem_dst = 5'd9;
        @(negedge clock);
        set_idle();
        id_redirect = 1;
        @(negedge clock);
        id_redirect = 1;
        @(negedge clock);
        set_idle();
        #1;
        n_checks++;
        if (stall_cycles !== exp_stalls || flush_count !== exp_flushes) begin
            $display("FAIL perf_counts: stalls %0d flushes %0d want %0d %0d",
                     stall_cycles, flush_count, exp_stalls, exp_flushes); n_fail++;
        end
        $display("test_perf done");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_and_qualify();
        test_branch();
        test_hilo();
        test_reset_mid_stall();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
